// File: rtl/alib_octree_pkg.sv
// Shared types for the octree frame controller: FSM states, signed coordinate
// type and the width of the per-frame point counters.
package alib_octree_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_PT,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_START_DFS,
    ST_WAIT_DFS,
    ST_DONE
  } state_e;

  typedef logic signed [15:0] coord_t;

  localparam int CNT_W = 32;

endpackage

// File: rtl/alib_octree_bb_check.sv
// Combinational inclusive bounding-box test on a signed 3D point.
module alib_octree_bb_check
  import alib_octree_pkg::*;
(
  input  logic signed [15:0] pt_x_i,
  input  logic signed [15:0] pt_y_i,
  input  logic signed [15:0] pt_z_i,
  input  logic signed [15:0] min_x_i,
  input  logic signed [15:0] min_y_i,
  input  logic signed [15:0] min_z_i,
  input  logic signed [15:0] max_x_i,
  input  logic signed [15:0] max_y_i,
  input  logic signed [15:0] max_z_i,
  output logic               in_box_o
);

  coord_t x, y, z;

  assign x = pt_x_i;
  assign y = pt_y_i;
  assign z = pt_z_i;

  assign in_box_o = (x >= min_x_i) && (x <= max_x_i) &&
                    (y >= min_y_i) && (y <= max_y_i) &&
                    (z >= min_z_i) && (z <= max_z_i);

endmodule

// File: rtl/alib_octree_frame_ctrl.sv
// Frame sequencer feeding a point stream into an octree handler, then a DFS.
// Optional bounding-box point filter: define ALIB_OCTREE_CTRL_BBFILTER_EN.
module alib_octree_frame_ctrl
  import alib_octree_pkg::*;
#(
  parameter int ACK_TIMEOUT  = 1024,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic               i_SYSTEM_clk,
  input  logic               i_SYSTEM_rst,
  input  logic               i_frame_start,
  input  logic               i_pt_valid,
  output logic               o_pt_ready,
  input  logic signed [15:0] i_pt_x,
  input  logic signed [15:0] i_pt_y,
  input  logic signed [15:0] i_pt_z,
  input  logic               i_pt_last,
  input  logic signed [15:0] i_BB_MIN_X,
  input  logic signed [15:0] i_BB_MIN_Y,
  input  logic signed [15:0] i_BB_MIN_Z,
  input  logic signed [15:0] i_BB_MAX_X,
  input  logic signed [15:0] i_BB_MAX_Y,
  input  logic signed [15:0] i_BB_MAX_Z,
  output logic               o_oct_reset_octree,
  output logic               o_oct_new_point,
  output logic               o_oct_start_dfs,
  output logic signed [15:0] o_oct_point_x,
  output logic signed [15:0] o_oct_point_y,
  output logic signed [15:0] o_oct_point_z,
  input  logic               i_oct_new_point_processed,
  input  logic               i_oct_dfs_done,
  input  logic               i_oct_all_nodes_occuppied,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_timeout,
  output logic [31:0]        o_points_accepted,
  output logic [31:0]        o_points_dropped
);

  localparam int CYC_MAX = (ACK_TIMEOUT > CLEAR_CYCLES) ? ACK_TIMEOUT : CLEAR_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  state_e             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   acc_q, acc_d, drop_q, drop_d;
  logic               drop_mode_q, drop_mode_d;
  logic               last_q, last_d;
  coord_t             pt_x_q, pt_x_d, pt_y_q, pt_y_d, pt_z_q, pt_z_d;
  logic               in_box;
  logic               tmo_hit;
  logic               occ_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef ALIB_OCTREE_CTRL_BBFILTER_EN
  alib_octree_bb_check u_bb_check (
    .pt_x_i  (i_pt_x),
    .pt_y_i  (i_pt_y),
    .pt_z_i  (i_pt_z),
    .min_x_i (i_BB_MIN_X),
    .min_y_i (i_BB_MIN_Y),
    .min_z_i (i_BB_MIN_Z),
    .max_x_i (i_BB_MAX_X),
    .max_y_i (i_BB_MAX_Y),
    .max_z_i (i_BB_MAX_Z),
    .in_box_o(in_box)
  );
`else
  logic unused_bb;
  assign unused_bb = ^{i_BB_MIN_X, i_BB_MIN_Y, i_BB_MIN_Z,
                       i_BB_MAX_X, i_BB_MAX_Y, i_BB_MAX_Z};
  assign in_box    = 1'b1;
`endif

  // Once the handler reports it is full, the rest of the frame is drained as drops.
  assign occ_now = i_oct_all_nodes_occuppied &&
                   (state_q == ST_WAIT_PT || state_q == ST_WAIT_ACK);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    drop_d      = drop_q;
    drop_mode_d = drop_mode_q | occ_now;
    last_d      = last_q;
    pt_x_d      = pt_x_q;
    pt_y_d      = pt_y_q;
    pt_z_d      = pt_z_q;
    tmo_hit     = 1'b0;
    cyc_d       = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_frame_start) begin
          state_d     = ST_CLEAR;
          acc_d       = '0;
          drop_d      = '0;
          drop_mode_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (cyc_q == CYC_W'(CLEAR_CYCLES - 1)) state_d = ST_WAIT_PT;
      end
      ST_WAIT_PT: begin
        if (i_pt_valid) begin
          pt_x_d = i_pt_x;
          pt_y_d = i_pt_y;
          pt_z_d = i_pt_z;
          last_d = i_pt_last;
          if (drop_mode_q || i_oct_all_nodes_occuppied || !in_box) begin
            drop_d  = sat_inc(drop_q);
            state_d = i_pt_last ? ST_START_DFS : ST_WAIT_PT;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (i_oct_new_point_processed) begin
          acc_d   = sat_inc(acc_q);
          state_d = last_q ? ST_START_DFS : ST_WAIT_PT;
        end else if (cyc_q == CYC_W'(ACK_TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_START_DFS: state_d = ST_WAIT_DFS;
      ST_WAIT_DFS: begin
        if (i_oct_dfs_done) begin
          state_d = ST_DONE;
        end else if (cyc_q == CYC_W'(ACK_TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Dwell counter restarts on every state entry; it only advances where it is consulted.
    if (state_d == state_q &&
        (state_q == ST_CLEAR || state_q == ST_WAIT_ACK || state_q == ST_WAIT_DFS))
      cyc_d = cyc_q + CYC_W'(1);
  end

  always_ff @(posedge i_SYSTEM_clk) begin
    if (i_SYSTEM_rst) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      acc_q       <= '0;
      drop_q      <= '0;
      drop_mode_q <= 1'b0;
      last_q      <= 1'b0;
      pt_x_q      <= '0;
      pt_y_q      <= '0;
      pt_z_q      <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      acc_q       <= acc_d;
      drop_q      <= drop_d;
      drop_mode_q <= drop_mode_d;
      last_q      <= last_d;
      pt_x_q      <= pt_x_d;
      pt_y_q      <= pt_y_d;
      pt_z_q      <= pt_z_d;
    end
  end

  assign o_pt_ready         = (state_q == ST_WAIT_PT);
  assign o_busy             = (state_q != ST_IDLE);
  assign o_oct_reset_octree = (state_q == ST_CLEAR);
  assign o_oct_new_point    = (state_q == ST_ISSUE);
  assign o_oct_start_dfs    = (state_q == ST_START_DFS);
  assign o_frame_done       = (state_q == ST_DONE);
  assign o_timeout          = tmo_hit;
  assign o_oct_point_x      = pt_x_q;
  assign o_oct_point_y      = pt_y_q;
  assign o_oct_point_z      = pt_z_q;
  assign o_points_accepted  = acc_q;
  assign o_points_dropped   = drop_q;

endmodule

// File: tb/tb_alib_octree_frame_ctrl.sv
// Directed bench for alib_octree_frame_ctrl with a scripted octree handler.
module tb_alib_octree_frame_ctrl;

  localparam int ACK_DLY = 5;
  localparam int DFS_DLY = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               frame_start = 1'b0;
  logic               pt_valid = 1'b0;
  logic               pt_ready;
  logic signed [15:0] pt_x = '0, pt_y = '0, pt_z = '0;
  logic               pt_last = 1'b0;
  logic signed [15:0] bb_min = -16'sd20000;
  logic signed [15:0] bb_max = 16'sd20000;
  logic               oct_reset, oct_new, oct_dfs;
  logic signed [15:0] oct_x, oct_y, oct_z;
  logic               np_done = 1'b0, dfs_done = 1'b0, occ = 1'b0;
  logic               busy, frame_done, timeout;
  logic [31:0]        acc, drop;

  int n_checks = 0;
  int n_fail   = 0;
  int mon_np = 0, mon_dfs = 0, mon_done = 0, mon_tmo = 0;
  bit ack_en = 1'b1;
  bit dfs_en = 1'b1;

  alib_octree_frame_ctrl #(.ACK_TIMEOUT(16), .CLEAR_CYCLES(2)) dut (
    .i_SYSTEM_clk             (clk),
    .i_SYSTEM_rst             (rst),
    .i_frame_start            (frame_start),
    .i_pt_valid               (pt_valid),
    .o_pt_ready               (pt_ready),
    .i_pt_x                   (pt_x),
    .i_pt_y                   (pt_y),
    .i_pt_z                   (pt_z),
    .i_pt_last                (pt_last),
    .i_BB_MIN_X               (bb_min),
    .i_BB_MIN_Y               (bb_min),
    .i_BB_MIN_Z               (bb_min),
    .i_BB_MAX_X               (bb_max),
    .i_BB_MAX_Y               (bb_max),
    .i_BB_MAX_Z               (bb_max),
    .o_oct_reset_octree       (oct_reset),
    .o_oct_new_point          (oct_new),
    .o_oct_start_dfs          (oct_dfs),
    .o_oct_point_x            (oct_x),
    .o_oct_point_y            (oct_y),
    .o_oct_point_z            (oct_z),
    .i_oct_new_point_processed(np_done),
    .i_oct_dfs_done           (dfs_done),
    .i_oct_all_nodes_occuppied(occ),
    .o_busy                   (busy),
    .o_frame_done             (frame_done),
    .o_timeout                (timeout),
    .o_points_accepted        (acc),
    .o_points_dropped         (drop)
  );

  always #5 clk = ~clk;

  // Handler model: ack a point ACK_DLY cycles after new_point, DFS done DFS_DLY after start.
  initial begin
    int ack_cnt;
    int dfs_cnt;
    ack_cnt = -1;
    dfs_cnt = -1;
    forever begin
      @(negedge clk);
      np_done  = 1'b0;
      dfs_done = 1'b0;
      if (oct_new && ack_en) ack_cnt = ACK_DLY;
      else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin np_done = 1'b1; ack_cnt = -1; end
      end
      if (oct_dfs && dfs_en) dfs_cnt = DFS_DLY;
      else if (dfs_cnt > 0) begin
        dfs_cnt--;
        if (dfs_cnt == 0) begin dfs_done = 1'b1; dfs_cnt = -1; end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (oct_new)    mon_np++;
    if (oct_dfs)    mon_dfs++;
    if (frame_done) mon_done++;
    if (timeout)    mon_tmo++;
  end

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic send_pt(input logic signed [15:0] x, y, z, input logic last);
    pt_valid = 1'b1; pt_x = x; pt_y = y; pt_z = z; pt_last = last;
    for (int k = 0; k < 200 && !pt_ready; k++) step();
    n_checks++;
    if (!pt_ready) begin
      n_fail++;
      $display("FAIL send_pt_ready: ready=%b required 1 within 200 cycles", pt_ready);
    end
    step();
    pt_valid = 1'b0; pt_last = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int d0, t0;
    d0 = mon_done; t0 = mon_tmo;
    for (int k = 0; k < 500 && mon_done == d0 && mon_tmo == t0; k++) step();
    n_checks++;
    if (mon_done == d0 && mon_tmo == t0) begin
      n_fail++;
      $display("FAIL %s_end: no frame_done/timeout within 500 cycles", tag);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({busy, pt_ready, oct_reset, oct_new, oct_dfs, frame_done, timeout} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {busy, pt_ready, oct_reset, oct_new, oct_dfs, frame_done, timeout});
    end
    n_checks++;
    if (acc !== 32'd0 || drop !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters: acc=%0d drop=%0d required 0/0", acc, drop);
    end
    n_checks++;
    if (oct_x !== 16'sd0 || oct_y !== 16'sd0 || oct_z !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_point: got %0d,%0d,%0d required 0,0,0", oct_x, oct_y, oct_z);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_clear();
    int np0;
    np0 = mon_np;
    pulse_start();
    n_checks++;
    if (oct_reset !== 1'b1 || busy !== 1'b1 || pt_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_c0: reset_oct=%b busy=%b ready=%b required 1,1,0", oct_reset, busy, pt_ready);
    end
    step();
    n_checks++;
    if (oct_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_c1: reset_oct=%b required 1", oct_reset);
    end
    step();
    n_checks++;
    if (oct_reset !== 1'b0 || pt_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_c2: reset_oct=%b ready=%b required 0,1", oct_reset, pt_ready);
    end
    send_pt(16'sd123, -16'sd45, 16'sd678, 1'b1);
    n_checks++;
    if (oct_new !== 1'b1 || pt_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_issue: new_point=%b ready=%b required 1,0", oct_new, pt_ready);
    end
    n_checks++;
    if (oct_x !== 16'sd123 || oct_y !== -16'sd45 || oct_z !== 16'sd678) begin
      n_fail++;
      $display("FAIL clear_point: got %0d,%0d,%0d required 123,-45,678", oct_x, oct_y, oct_z);
    end
    wait_end("clear");
    n_checks++;
    if (busy !== 1'b0 || acc !== 32'd1 || mon_np - np0 != 1) begin
      n_fail++;
      $display("FAIL clear_result: busy=%b acc=%0d issues=%0d required 0,1,1", busy, acc, mon_np - np0);
    end
  endtask

  task automatic test_ten_points();
    int np0, dfs0, done0;
    np0 = mon_np; dfs0 = mon_dfs; done0 = mon_done;
    pulse_start();
    for (int i = 1; i <= 10; i++)
      send_pt(16'(i * 100), 16'(-i * 50), 16'(i), (i == 10));
    wait_end("ten");
    n_checks++;
    if (mon_np - np0 != 10 || mon_dfs - dfs0 != 1 || mon_done - done0 != 1) begin
      n_fail++;
      $display("FAIL ten_pulses: issues=%0d dfs=%0d done=%0d required 10,1,1",
               mon_np - np0, mon_dfs - dfs0, mon_done - done0);
    end
    n_checks++;
    if (acc !== 32'd10 || drop !== 32'd0) begin
      n_fail++;
      $display("FAIL ten_counters: acc=%0d drop=%0d required 10/0", acc, drop);
    end
  endtask

  task automatic test_bbfilter();
    int np0;
    logic [31:0] exp_acc, exp_drop;
`ifdef ALIB_OCTREE_CTRL_BBFILTER_EN
    exp_acc = 32'd4; exp_drop = 32'd1;
`else
    exp_acc = 32'd5; exp_drop = 32'd0;
`endif
    np0 = mon_np;
    pulse_start();
    send_pt(16'sd100, 16'sd200, 16'sd300, 1'b0);
    send_pt(-16'sd100, 16'sd50, 16'sd0, 1'b0);
    send_pt(16'sd25000, 16'sd0, 16'sd0, 1'b0);
    send_pt(16'sd0, -16'sd19999, 16'sd20000, 1'b0);
    send_pt(16'sd1, 16'sd1, 16'sd1, 1'b1);
    wait_end("bb");
    n_checks++;
    if (acc !== exp_acc || drop !== exp_drop) begin
      n_fail++;
      $display("FAIL bb_counters: acc=%0d drop=%0d required %0d/%0d", acc, drop, exp_acc, exp_drop);
    end
    n_checks++;
    if (mon_np - np0 != int'(exp_acc)) begin
      n_fail++;
      $display("FAIL bb_issues: issues=%0d required %0d", mon_np - np0, exp_acc);
    end
  endtask

  task automatic test_occupied();
    int np0, dfs0;
    np0 = mon_np; dfs0 = mon_dfs;
    pulse_start();
    for (int i = 1; i <= 3; i++) send_pt(16'(i), 16'(i), 16'(i), 1'b0);
    for (int k = 0; k < 100 && acc != 32'd3; k++) step();
    occ = 1'b1;
    pulse_start();
    n_checks++;
    if (acc !== 32'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL occ_start_ignored: acc=%0d busy=%b required 3,1", acc, busy);
    end
    for (int i = 4; i <= 8; i++) send_pt(16'(i), 16'(i), 16'(i), (i == 8));
    wait_end("occ");
    occ = 1'b0;
    n_checks++;
    if (acc !== 32'd3 || drop !== 32'd5) begin
      n_fail++;
      $display("FAIL occ_counters: acc=%0d drop=%0d required 3/5", acc, drop);
    end
    n_checks++;
    if (mon_np - np0 != 3 || mon_dfs - dfs0 != 1) begin
      n_fail++;
      $display("FAIL occ_pulses: issues=%0d dfs=%0d required 3,1", mon_np - np0, mon_dfs - dfs0);
    end
  endtask

  task automatic test_timeout();
    int k;
    ack_en = 1'b0;
    pulse_start();
    send_pt(16'sd7, 16'sd8, 16'sd9, 1'b0);
    n_checks++;
    if (oct_new !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_issue: new_point=%b required 1", oct_new);
    end
    k = 0;
    while (k < 100 && timeout !== 1'b1) begin step(); k++; end
    n_checks++;
    if (k != 16) begin
      n_fail++;
      $display("FAIL tmo_latency: timeout after %0d cycles required 16", k);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || timeout !== 1'b0 || acc !== 32'd0) begin
      n_fail++;
      $display("FAIL tmo_idle: busy=%b timeout=%b acc=%0d required 0,0,0", busy, timeout, acc);
    end
    ack_en = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_frame();
    dfs_en = 1'b0;
    pulse_start();
    send_pt(16'sd11, 16'sd22, 16'sd33, 1'b1);
    for (int k = 0; k < 100 && oct_dfs !== 1'b1; k++) step();
    step();
    n_checks++;
    if (busy !== 1'b1 || oct_dfs !== 1'b0 || acc !== 32'd1) begin
      n_fail++;
      $display("FAIL mid_wait_dfs: busy=%b start_dfs=%b acc=%0d required 1,0,1", busy, oct_dfs, acc);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if ({busy, pt_ready, oct_reset, oct_new, oct_dfs, frame_done, timeout} !== 7'b0 ||
        acc !== 32'd0 || drop !== 32'd0 || oct_x !== 16'sd0) begin
      n_fail++;
      $display("FAIL mid_reset: ctrl=%b acc=%0d drop=%0d x=%0d required 0000000,0,0,0",
               {busy, pt_ready, oct_reset, oct_new, oct_dfs, frame_done, timeout}, acc, drop, oct_x);
    end
    rst = 1'b0;
    dfs_en = 1'b1;
    step();
    pulse_start();
    send_pt(16'sd1, 16'sd2, 16'sd3, 1'b0);
    send_pt(16'sd4, 16'sd5, 16'sd6, 1'b1);
    wait_end("rerun");
    n_checks++;
    if (acc !== 32'd2 || drop !== 32'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rerun_result: acc=%0d drop=%0d busy=%b required 2,0,0", acc, drop, busy);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_ten_points();
    test_bbfilter();
    test_occupied();
    test_timeout();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
